// File: rtl/rock_scheduler_if.sv
// Rock scheduler bus: spawn control, slot status and retire pulses.
// Ports: master drives enable/clearAll/maxActive/inUse/rockHit; slave drives the rest.
interface rock_scheduler_if #(
    parameter int NSLOT = 8
);
    logic             enable;
    logic             clearAll;
    logic [3:0]       maxActive;
    logic [NSLOT-1:0] inUse;
    logic [NSLOT-1:0] rockHit;
    logic [NSLOT-1:0] start;
    logic [NSLOT-1:0] rockReset;
    logic [9:0]       initialX;
    logic [9:0]       initialY;
    logic [2:0]       dirX;
    logic [2:0]       dirY;
    logic [3:0]       activeCount;
    logic [7:0]       hitCount;
    logic             spawnFail;

    modport master (
        output enable, clearAll, maxActive, inUse, rockHit,
        input  start, rockReset, initialX, initialY,
        input  dirX, dirY, activeCount, hitCount, spawnFail
    );

    modport slave (
        input  enable, clearAll, maxActive, inUse, rockHit,
        output start, rockReset, initialX, initialY,
        output dirX, dirY, activeCount, hitCount, spawnFail
    );
endinterface

// File: rtl/rock_scheduler.sv
// Rock scheduler: periodic spawning into free slots, lifetime/hit retirement.
// Ports: clk60hz (frame clock), reset (async, active-high), sched (slave bus).
module rock_scheduler #(
    parameter int NSLOT        = 8,
    parameter int SPAWN_PERIOD = 90,
    parameter int LIFETIME     = 400
) (
    input  logic             clk60hz,
    input  logic             reset,
    rock_scheduler_if.slave  sched
);

    localparam int IW  = (NSLOT > 1) ? $clog2(NSLOT) : 1;
    localparam int IW1 = IW + 1;
    localparam int TW  = $clog2(SPAWN_PERIOD + 4) + 1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        SEARCH,
        ISSUE,
        CONFIRM
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [TW-1:0]    r_timer;
    logic [IW-1:0]    r_rr;
    logic [IW-1:0]    r_idx;
    logic [IW-1:0]    w_sel;
    logic [IW1-1:0]   w_sum;
    logic             w_found;
    logic [15:0]      r_lfsr;
    logic             w_fb;
    logic [9:0]       r_x;
    logic [9:0]       r_y;
    logic [2:0]       r_dx;
    logic [2:0]       r_dy;
    logic [9:0]       w_x;
    logic [9:0]       w_y;
    logic [2:0]       w_dx;
    logic [2:0]       w_dy;
    logic [1:0]       w_spd;
    logic [8:0]       r_life [NSLOT];
    logic [NSLOT-1:0] r_rst;
    logic [NSLOT-1:0] r_block;
    logic [NSLOT-1:0] w_live;
    logic [NSLOT-1:0] w_hit;
    logic [NSLOT-1:0] w_exp;
    logic [NSLOT-1:0] w_ret;
    logic [NSLOT-1:0] w_start;
    logic [7:0]       r_hits;
    logic [3:0]       w_nhit;
    logic [8:0]       w_hsum;
    logic [3:0]       w_active;
    logic             r_fail;
    logic             w_tclr;
    logic             w_latch;
    logic             w_ok;
    logic             w_bad;

    // Population count of busy slots.
    always_comb begin
        w_active = '0;
        for (int i = 0; i < NSLOT; i++) begin
            w_active = w_active + 4'(sched.inUse[i]);
        end
    end

    // First free slot, scanning upward from the round-robin pointer.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_sum   = '0;
        for (int k = 0; k < NSLOT; k++) begin
            w_sum = {1'b0, r_rr} + IW1'(k);
            if (w_sum >= IW1'(NSLOT)) begin
                w_sum = w_sum - IW1'(NSLOT);
            end
            if (!w_found && !sched.inUse[w_sum[IW-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_sum[IW-1:0];
            end
        end
    end

    // Spawn geometry decoded from the current LFSR value.
    always_comb begin
        w_spd = (r_lfsr[3:2] == 2'b00) ? 2'b01 : r_lfsr[3:2];
        w_x   = 10'd64 + {1'b0, r_lfsr[15:7]};
        w_y   = '0;
        w_dx  = r_lfsr[6:4];
        w_dy  = {1'b0, w_spd};
        case (r_lfsr[1:0])
            2'd0: begin
                w_y  = '0;
            end
            2'd1: begin
                w_y  = 10'd479;
                w_dy = {1'b1, w_spd};
            end
            2'd2: begin
                w_x  = '0;
                w_y  = 10'd112 + {2'b00, r_lfsr[15:8]};
                w_dx = {1'b0, w_spd};
                w_dy = r_lfsr[6:4];
            end
            default: begin
                w_x  = 10'd639;
                w_y  = 10'd112 + {2'b00, r_lfsr[15:8]};
                w_dx = {1'b1, w_spd};
                w_dy = r_lfsr[6:4];
            end
        endcase
    end

    assign w_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

    // Next-state logic; clearAll overrides every state.
    always_comb begin
        w_state_nx = r_state;
        w_tclr     = 1'b0;
        w_latch    = 1'b0;
        w_ok       = 1'b0;
        w_bad      = 1'b0;
        if (sched.clearAll) begin
            w_state_nx = sched.enable ? WAIT : IDLE;
            w_tclr     = 1'b1;
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_tclr = 1'b1;
                    if (sched.enable) begin
                        w_state_nx = WAIT;
                    end
                end
                WAIT: begin
                    if (!sched.enable) begin
                        w_state_nx = IDLE;
                        w_tclr     = 1'b1;
                    end else if (r_timer >= TW'(SPAWN_PERIOD - 1)) begin
                        w_state_nx = SEARCH;
                        w_tclr     = 1'b1;
                    end
                end
                SEARCH: begin
                    if (!sched.enable) begin
                        w_state_nx = IDLE;
                    end else if (!w_found || w_active >= sched.maxActive) begin
                        w_state_nx = WAIT;
                    end else begin
                        w_state_nx = ISSUE;
                        w_latch    = 1'b1;
                    end
                end
                ISSUE: begin
                    w_state_nx = CONFIRM;
                end
                CONFIRM: begin
                    w_ok       = sched.inUse[r_idx];
                    w_bad      = !sched.inUse[r_idx];
                    w_state_nx = sched.enable ? WAIT : IDLE;
                end
                default: begin
                    w_state_nx = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk60hz or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Timer keeps running through the spawn handshake so attempts stay
    // exactly SPAWN_PERIOD frames apart.
    always_ff @(posedge clk60hz or posedge reset) begin
        if (reset) begin
            r_timer <= '0;
            r_rr    <= '0;
            r_idx   <= '0;
            r_lfsr  <= 16'hACE1;
            r_x     <= '0;
            r_y     <= '0;
            r_dx    <= '0;
            r_dy    <= '0;
            r_fail  <= 1'b0;
        end else begin
            if (w_tclr) begin
                r_timer <= '0;
            end else if (r_timer != '1) begin
                r_timer <= r_timer + TW'(1);
            end
            if (w_latch) begin
                r_idx <= w_sel;
                r_x   <= w_x;
                r_y   <= w_y;
                r_dx  <= w_dx;
                r_dy  <= w_dy;
            end
            if (r_state == ISSUE) begin
                r_lfsr <= {w_fb, r_lfsr[15:1]};
            end
            if (w_ok) begin
                r_rr <= (r_idx == IW'(NSLOT - 1)) ? '0 : r_idx + IW'(1);
            end
            if (w_bad) begin
                r_fail <= 1'b1;
            end
        end
    end

    // Retirement; r_block suppresses repeats until the slot goes idle.
    always_comb begin
        w_live = sched.inUse & ~r_block;
        w_hit  = sched.rockHit & w_live;
        w_exp  = '0;
        w_nhit = '0;
        for (int i = 0; i < NSLOT; i++) begin
            w_exp[i] = w_live[i] & (r_life[i] == 9'(LIFETIME - 1));
            w_nhit   = w_nhit + 4'(w_hit[i]);
        end
        w_ret  = w_hit | w_exp;
        w_hsum = {1'b0, r_hits} + {5'd0, w_nhit};
    end

    always_ff @(posedge clk60hz or posedge reset) begin
        if (reset) begin
            r_rst   <= '0;
            r_block <= '0;
            r_hits  <= '0;
        end else if (sched.clearAll) begin
            r_rst   <= '1;
            r_block <= '1;
        end else begin
            r_rst   <= w_ret;
            r_block <= w_ret | (r_block & sched.inUse);
            r_hits  <= w_hsum[8] ? 8'hFF : w_hsum[7:0];
        end
    end

    always_ff @(posedge clk60hz or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NSLOT; i++) begin
                r_life[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NSLOT; i++) begin
                if (!sched.inUse[i] || (w_ok && r_idx == IW'(i))) begin
                    r_life[i] <= '0;
                end else if (r_life[i] != 9'h1FF) begin
                    r_life[i] <= r_life[i] + 9'd1;
                end
            end
        end
    end

    // start is decoded from state so an async reset drops it at once.
    always_comb begin
        w_start = '0;
        if (r_state == ISSUE) begin
            w_start[r_idx] = 1'b1;
        end
        w_start = w_start & ~r_rst;
    end

    assign sched.start       = w_start;
    assign sched.rockReset   = r_rst;
    assign sched.initialX    = r_x;
    assign sched.initialY    = r_y;
    assign sched.dirX        = r_dx;
    assign sched.dirY        = r_dy;
    assign sched.activeCount = w_active;
    assign sched.hitCount    = r_hits;
    assign sched.spawnFail   = r_fail;

endmodule

// File: tb/tb_rock_scheduler.sv
// Directed bench for rock_scheduler: spawn timing, geometry, retire, fail, clear.
// Ports: none; drives the interface and a simple echoing slot model.
module tb_rock_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   cur = 0;
    bit   echo = 1'b0;

    rock_scheduler_if #(.NSLOT(8)) bus ();

    rock_scheduler #(
        .NSLOT(8),
        .SPAWN_PERIOD(90),
        .LIFETIME(400)
    ) dut (
        .clk60hz(clk),
        .reset(rst),
        .sched(bus)
    );

    always #5 clk = ~clk;

    // One frame: sample point is 1 after the edge; the slot model then
    // latches start and drops retired slots.
    task automatic tick();
        @(posedge clk);
        #1;
        if (echo) bus.inUse = (bus.inUse | bus.start) & ~bus.rockReset;
        #1;
        cur++;
    endtask

    task automatic wait_to(input int n);
        while (cur < n) tick();
    endtask

    // Cycle 0 is the first edge that sees enable=1 out of reset.
    task automatic begin_run(input bit e);
        rst = 1'b1;
        bus.enable = 1'b0;
        bus.clearAll = 1'b0;
        bus.rockHit = '0;
        bus.inUse = '0;
        bus.maxActive = 4'd8;
        echo = e;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.enable = 1'b1;
        cur = -1;
        tick();
    endtask

    task automatic test_reset();
        bus.enable = 1'b1;
        bus.clearAll = 1'b0;
        bus.rockHit = '0;
        bus.inUse = '0;
        bus.maxActive = 4'd8;
        #3 rst = 1'b1;
        #1;
        vectors++;
        if ({bus.start, bus.rockReset, bus.initialX, bus.initialY, bus.dirX,
             bus.dirY, bus.hitCount, bus.spawnFail} !== 53'd0) begin
            miscompares++;
            $display("FAIL reset_outs: got start=%h rr=%h x=%0d y=%0d h=%0d f=%b want 0",
                     bus.start, bus.rockReset, bus.initialX, bus.initialY,
                     bus.hitCount, bus.spawnFail);
        end
        vectors++;
        if (bus.activeCount !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_active: got %0d want 0", bus.activeCount);
        end
    endtask

    task automatic test_spawn();
        begin_run(1'b1);
        wait_to(90);
        vectors++;
        if (bus.start !== 8'h00) begin
            miscompares++;
            $display("FAIL start_c90: got %h want 00", bus.start);
        end
        wait_to(91);
        vectors++;
        if (bus.start !== 8'h01) begin
            miscompares++;
            $display("FAIL start_c91: got %h want 01", bus.start);
        end
        vectors++;
        if ({bus.initialX, bus.initialY, bus.dirX, bus.dirY} !==
            {10'd409, 10'd479, 3'd6, 3'd5}) begin
            miscompares++;
            $display("FAIL geom1_issue: got x=%0d y=%0d dx=%0d dy=%0d want 409 479 6 5",
                     bus.initialX, bus.initialY, bus.dirX, bus.dirY);
        end
        wait_to(92);
        vectors++;
        if ({bus.start, bus.initialX, bus.initialY, bus.dirX, bus.dirY} !==
            {8'h00, 10'd409, 10'd479, 3'd6, 3'd5}) begin
            miscompares++;
            $display("FAIL geom1_confirm: got s=%h x=%0d y=%0d dx=%0d dy=%0d",
                     bus.start, bus.initialX, bus.initialY, bus.dirX, bus.dirY);
        end
        vectors++;
        if (bus.activeCount !== 4'd1) begin
            miscompares++;
            $display("FAIL active_c92: got %0d want 1", bus.activeCount);
        end
        wait_to(181);
        vectors++;
        if (bus.start !== 8'h02) begin
            miscompares++;
            $display("FAIL start_c181: got %h want 02", bus.start);
        end
        vectors++;
        if ({bus.initialX, bus.initialY, bus.dirX, bus.dirY} !==
            {10'd236, 10'd0, 3'd7, 3'd1}) begin
            miscompares++;
            $display("FAIL geom2: got x=%0d y=%0d dx=%0d dy=%0d want 236 0 7 1",
                     bus.initialX, bus.initialY, bus.dirX, bus.dirY);
        end
        wait_to(271);
        vectors++;
        if (bus.start !== 8'h04) begin
            miscompares++;
            $display("FAIL start_c271: got %h want 04", bus.start);
        end
        wait_to(361);
        vectors++;
        if (bus.start !== 8'h08) begin
            miscompares++;
            $display("FAIL start_c361: got %h want 08", bus.start);
        end
        wait_to(451);
        vectors++;
        if (bus.start !== 8'h10) begin
            miscompares++;
            $display("FAIL start_c451: got %h want 10", bus.start);
        end
        vectors++;
        if ({bus.initialX, bus.initialY, bus.dirX, bus.dirY} !==
            {10'd0, 10'd154, 3'd3, 3'd4}) begin
            miscompares++;
            $display("FAIL geom5_left: got x=%0d y=%0d dx=%0d dy=%0d want 0 154 3 4",
                     bus.initialX, bus.initialY, bus.dirX, bus.dirY);
        end
        vectors++;
        if (bus.activeCount !== 4'd5) begin
            miscompares++;
            $display("FAIL active_c451: got %0d want 5", bus.activeCount);
        end
    endtask

    task automatic test_lifetime();
        wait_to(492);
        vectors++;
        if (bus.rockReset !== 8'h00) begin
            miscompares++;
            $display("FAIL life_c492: got %h want 00", bus.rockReset);
        end
        wait_to(493);
        vectors++;
        if (bus.rockReset !== 8'h01) begin
            miscompares++;
            $display("FAIL life_c493: got %h want 01", bus.rockReset);
        end
        vectors++;
        if (bus.hitCount !== 8'd0) begin
            miscompares++;
            $display("FAIL life_hits: got %0d want 0", bus.hitCount);
        end
        wait_to(494);
        vectors++;
        if (bus.rockReset !== 8'h00) begin
            miscompares++;
            $display("FAIL life_c494: got %h want 00", bus.rockReset);
        end
        vectors++;
        if (bus.activeCount !== 4'd4) begin
            miscompares++;
            $display("FAIL life_active: got %0d want 4", bus.activeCount);
        end
    endtask

    task automatic test_hit();
        wait_to(500);
        bus.rockHit = 8'h04;
        wait_to(501);
        vectors++;
        if (bus.rockReset !== 8'h04) begin
            miscompares++;
            $display("FAIL hit_pulse: got %h want 04", bus.rockReset);
        end
        vectors++;
        if (bus.hitCount !== 8'd1) begin
            miscompares++;
            $display("FAIL hit_count: got %0d want 1", bus.hitCount);
        end
        bus.rockHit = 8'h01;
        wait_to(502);
        vectors++;
        if ({bus.rockReset, bus.hitCount} !== {8'h00, 8'd1}) begin
            miscompares++;
            $display("FAIL hit_free_slot: got rr=%h h=%0d want 00 1",
                     bus.rockReset, bus.hitCount);
        end
        echo = 1'b0;
        bus.rockHit = 8'h08;
        wait_to(503);
        vectors++;
        if ({bus.rockReset, bus.hitCount} !== {8'h08, 8'd2}) begin
            miscompares++;
            $display("FAIL hit_hold_1: got rr=%h h=%0d want 08 2",
                     bus.rockReset, bus.hitCount);
        end
        wait_to(504);
        vectors++;
        if (bus.rockReset !== 8'h00) begin
            miscompares++;
            $display("FAIL hit_hold_2: got %h want 00", bus.rockReset);
        end
        wait_to(505);
        vectors++;
        if ({bus.rockReset, bus.hitCount} !== {8'h00, 8'd2}) begin
            miscompares++;
            $display("FAIL hit_hold_3: got rr=%h h=%0d want 00 2",
                     bus.rockReset, bus.hitCount);
        end
        bus.rockHit = '0;
    endtask

    task automatic test_fail();
        begin_run(1'b0);
        wait_to(91);
        vectors++;
        if (bus.start !== 8'h01) begin
            miscompares++;
            $display("FAIL fail_start1: got %h want 01", bus.start);
        end
        wait_to(92);
        vectors++;
        if (bus.spawnFail !== 1'b0) begin
            miscompares++;
            $display("FAIL fail_c92: got %b want 0", bus.spawnFail);
        end
        wait_to(93);
        vectors++;
        if (bus.spawnFail !== 1'b1) begin
            miscompares++;
            $display("FAIL fail_c93: got %b want 1", bus.spawnFail);
        end
        wait_to(181);
        vectors++;
        if (bus.start !== 8'h01) begin
            miscompares++;
            $display("FAIL fail_rr_kept: got %h want 01", bus.start);
        end
        wait_to(183);
        vectors++;
        if (bus.spawnFail !== 1'b1) begin
            miscompares++;
            $display("FAIL fail_sticky: got %b want 1", bus.spawnFail);
        end
    endtask

    task automatic test_clear_and_skip();
        logic [7:0] seen;
        begin_run(1'b0);
        wait_to(92);
        bus.clearAll = 1'b1;
        wait_to(93);
        bus.clearAll = 1'b0;
        vectors++;
        if ({bus.rockReset, bus.spawnFail} !== {8'hFF, 1'b0}) begin
            miscompares++;
            $display("FAIL clear_pulse: got rr=%h f=%b want ff 0",
                     bus.rockReset, bus.spawnFail);
        end
        wait_to(94);
        vectors++;
        if ({bus.rockReset, bus.spawnFail, bus.hitCount} !== {8'h00, 1'b0, 8'd0}) begin
            miscompares++;
            $display("FAIL clear_after: got rr=%h f=%b h=%0d want 00 0 0",
                     bus.rockReset, bus.spawnFail, bus.hitCount);
        end
        wait_to(183);
        vectors++;
        if (bus.start !== 8'h00) begin
            miscompares++;
            $display("FAIL clear_c183: got %h want 00", bus.start);
        end
        wait_to(184);
        vectors++;
        if (bus.start !== 8'h01) begin
            miscompares++;
            $display("FAIL clear_c184: got %h want 01", bus.start);
        end
        bus.inUse = 8'hFF;
        wait_to(185);
        vectors++;
        if (bus.activeCount !== 4'd8) begin
            miscompares++;
            $display("FAIL full_active: got %0d want 8", bus.activeCount);
        end
        seen = '0;
        while (cur < 300) begin
            tick();
            seen = seen | bus.start;
        end
        vectors++;
        if ({seen, bus.spawnFail} !== {8'h00, 1'b0}) begin
            miscompares++;
            $display("FAIL full_skip: got starts=%h f=%b want 00 0",
                     seen, bus.spawnFail);
        end
        bus.inUse = 8'h01;
        bus.maxActive = 4'd1;
        seen = '0;
        while (cur < 371) begin
            tick();
            seen = seen | bus.start;
        end
        vectors++;
        if (seen !== 8'h00) begin
            miscompares++;
            $display("FAIL cap_skip: got starts=%h want 00", seen);
        end
        bus.maxActive = 4'd2;
        wait_to(454);
        vectors++;
        if (bus.start !== 8'h02) begin
            miscompares++;
            $display("FAIL cap_raised: got %h want 02", bus.start);
        end
        bus.inUse = 8'h03;
        wait_to(456);
        vectors++;
        if (bus.spawnFail !== 1'b0) begin
            miscompares++;
            $display("FAIL cap_confirm: got %b want 0", bus.spawnFail);
        end
    endtask

    task automatic test_reset_mid_issue();
        begin_run(1'b1);
        wait_to(91);
        vectors++;
        if (bus.start !== 8'h01) begin
            miscompares++;
            $display("FAIL mid_start: got %h want 01", bus.start);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({bus.start, bus.rockReset, bus.initialX, bus.initialY, bus.dirX,
             bus.dirY, bus.hitCount, bus.spawnFail} !== 53'd0) begin
            miscompares++;
            $display("FAIL mid_reset: got start=%h x=%0d y=%0d dx=%0d dy=%0d want 0",
                     bus.start, bus.initialX, bus.initialY, bus.dirX, bus.dirY);
        end
        begin_run(1'b1);
        wait_to(91);
        vectors++;
        if ({bus.start, bus.initialX} !== {8'h01, 10'd409}) begin
            miscompares++;
            $display("FAIL mid_restart: got s=%h x=%0d want 01 409",
                     bus.start, bus.initialX);
        end
    endtask

    initial begin
        test_reset();
        test_spawn();
        test_lifetime();
        test_hit();
        test_fail();
        test_clear_and_skip();
        test_reset_mid_issue();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
